rr_arb_4: RTL and testbench
===========================

RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 The block SHALL have parameter: WIDTH, default 4, data width of each channel and of the output.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: d0, d1, d2, d3  input  WIDTH each  channel data.
REQ-005 The block SHALL have port: req_valid  input  4  bit i = channel i holds a valid beat.
REQ-006 The block SHALL have port: req_ready  output  4  bit i = channel i beat accepted this cycle.
REQ-007 The block SHALL have port: out_valid  output  1  output register holds a beat.
REQ-008 The block SHALL have port: out_ready  input  1  downstream accepts the beat this cycle.
REQ-009 The block SHALL have port: out_data  output  WIDTH  registered data of the granted channel.
REQ-010 The block SHALL have port: out_sel  output  2  registered index of the channel that supplied out_data, for a downstream 4:1 mux.
REQ-011 The block SHALL use one clock domain; reset SHALL be asynchronous and active-high.

Function
REQ-012 The block SHALL hold a 2-bit priority pointer ptr and a one-beat output register (out_valid, out_data, out_sel).
REQ-013 The block SHALL define can_accept = !out_valid || out_ready, combinational.
REQ-014 The grant SHALL be the first i with req_valid[i]=1, searched in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-015 req_ready SHALL be one-hot at the granted index when can_accept=1 and req_valid!=0, else all zero.
REQ-016 req_ready SHALL depend combinationally on req_valid, ptr, out_valid, out_ready only.
REQ-017 A transfer from channel i SHALL occur on a clock edge where req_valid[i] && req_ready[i].
REQ-018 On a transfer, the block SHALL load out_data <= d[i], out_sel <= i, out_valid <= 1, ptr <= (i+1) mod 4.
REQ-019 Latency SHALL be 1 cycle from transfer edge to out_valid=1; throughput SHALL be 1 beat per cycle with out_ready held at 1.
REQ-020 When out_valid && out_ready and no transfer occurs, out_valid SHALL go 0; out_data and out_sel SHALL retain their values.
REQ-021 When out_valid && !out_ready, out_valid, out_data, out_sel and ptr SHALL hold, and req_ready SHALL be 0.
REQ-022 A pop and a push on the same edge SHALL both occur: out_valid stays 1 and the new beat replaces the old.
REQ-023 ptr SHALL change only on a transfer and SHALL wrap 3 -> 0.
REQ-024 Channel data SHALL never be dropped or duplicated: each accepted beat SHALL appear on the output exactly once.

Reset
REQ-025 While rst=1, the block SHALL immediately force out_valid=0, out_data=0, out_sel=0 and ptr=0, independent of clk.
REQ-026 An rst assertion mid-operation SHALL discard any held beat; the first post-reset grant SHALL start the search at channel 0.
REQ-027 After rst deasserts, req_ready SHALL follow REQ-015; with out_valid=0, it is nonzero whenever req_valid!=0.

Verification
REQ-028 Round robin: all req_valid=1111, d0..d3=A,B,C,D, out_ready=1 from reset -> out_sel 0,1,2,3,0 and out_data A,B,C,D,A on consecutive cycles.
REQ-029 Single requester: only req_valid[2]=1, out_ready=1 -> req_ready=0100 every cycle, out_sel=2 every cycle, ptr cycles 3 and keeps re-granting 2.
REQ-030 Skip idle: ptr=2, req_valid=1010 -> grant 3 first, then 1; out_sel 3 then 1.
REQ-031 Backpressure: out_valid=1, out_data=5, out_ready=0 for 3 cycles -> req_ready=0000, out_data=5 held; out_ready=1 -> next beat on out_data the following cycle.
REQ-032 Drain: out_valid=1, out_ready=1, req_valid=0000 -> out_valid=0 next cycle, out_data unchanged.
REQ-033 Async reset: assert rst between edges with out_valid=1, out_sel=3 -> out_valid=0, out_data=0, out_sel=0 before the next edge; the next grant with req_valid=1111 is channel 0.

Source files
------------

// File: rtl/rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_4
// Purpose  : Four-channel round-robin arbiter with a one-beat registered
//            output stage. A rotating 2-bit priority pointer picks the first
//            valid channel starting at ptr; the winner's data is captured
//            into the output register together with its channel index.
//            The pointer moves past the winner on every accepted beat, so
//            no continuously requesting channel can be starved.
// Ports    : clk        - single clock, rising-edge
//            rst        - asynchronous, active-high reset
//            d0..d3     - channel data, WIDTH bits each
//            req_valid  - per-channel valid (bit i = channel i)
//            req_ready  - per-channel accept, one-hot or zero
//            out_valid  - output register holds a beat
//            out_ready  - downstream accepts the held beat this cycle
//            out_data   - registered data of the granted channel
//            out_sel    - registered index of the granted channel
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_out_sel;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic             w_can_accept;
    logic             w_found;
    logic [1:0]       w_gnt;
    logic [1:0]       w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    // The output register can take a new beat when it is empty, or when
    // its current beat is leaving on this same edge (pop + push).
    assign w_can_accept = !r_out_valid || out_ready;

    // Priority search in order ptr, ptr+1, ptr+2, ptr+3. The 2-bit index
    // wraps naturally, so no explicit modulo is needed.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    // A grant is only offered when the output stage can absorb it, so
    // under backpressure every channel sees req_ready = 0.
    always_comb begin
        req_ready = 4'b0000;
        if (w_can_accept && w_found) begin
            req_ready = 4'b0001 << w_gnt;
        end
    end

    // req_ready is only ever raised on a valid channel, so a transfer is
    // simply "a grant was offered".
    assign w_xfer = w_can_accept && w_found;

    always_comb begin
        w_gnt_data = d0;
        case (w_gnt)
            2'd0:    w_gnt_data = d0;
            2'd1:    w_gnt_data = d1;
            2'd2:    w_gnt_data = d2;
            default: w_gnt_data = d3;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and priority pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= 2'd0;
        end else if (w_xfer) begin
            // New beat replaces (or fills) the output register; the
            // pointer moves just past the winner.
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_sel   <= w_gnt;
            r_ptr       <= w_gnt + 2'd1;
        end else if (r_out_valid && out_ready) begin
            // Drain with nothing to replace it: data and sel keep their
            // last values so a downstream mux sees a stable selection.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_4
// Purpose  : Self-checking bench for rr_arb_4. Directed vectors state the
//            expected req_ready/out_valid each cycle; every granted beat
//            pushes its expected {sel, data} into a scoreboard queue, and an
//            independent monitor pops and compares each beat the DUT hands
//            downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_4;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] dv [4];
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W+1:0] sb [$];

    rr_arb_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .d0        (dv[0]),
        .d1        (dv[1]),
        .d2        (dv[2]),
        .d3        (dv[3]),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs just after a rising edge, check the
    // combinational grant and out_valid at the falling edge, record the
    // expected beat if a grant is expected, then advance past the next edge.
    task automatic cyc(input logic [3:0] rv, input logic ordy,
                       input logic [3:0] exp_rr, input logic exp_ov,
                       input string name);
        logic [1:0] idx;
        req_valid = rv;
        out_ready = ordy;
        @(negedge clk);
        check({name, ".req_ready"}, 32'(req_ready), 32'(exp_rr));
        check({name, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        if (exp_rr != 4'b0000) begin
            case (exp_rr)
                4'b0001: idx = 2'd0;
                4'b0010: idx = 2'd1;
                4'b0100: idx = 2'd2;
                default: idx = 2'd3;
            endcase
            sb.push_back({idx, dv[idx]});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat that leaves the output register must be the
    // oldest expected beat; a beat with nothing expected is a duplicate.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL beat: got sel=%0d data=%0h expected no beat at %0t",
                         out_sel, out_data, $time);
            end else begin
                logic [W+1:0] e;
                e = sb.pop_front();
                check("beat.sel_data", 32'({out_sel, out_data}), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        dv[0] = 4'hA; dv[1] = 4'hB; dv[2] = 4'hC; dv[3] = 4'hD;

        // Reset state
        #2;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.out_sel",   32'(out_sel),   32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin from reset: 0,1,2,3,0 back to back
        cyc(4'b1111, 1'b1, 4'b0001, 1'b0, "rr0");
        cyc(4'b1111, 1'b1, 4'b0010, 1'b1, "rr1");
        cyc(4'b1111, 1'b1, 4'b0100, 1'b1, "rr2");
        cyc(4'b1111, 1'b1, 4'b1000, 1'b1, "rr3");
        cyc(4'b1111, 1'b1, 4'b0001, 1'b1, "rr4");

        // Drain: last beat leaves, data retained
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "drain");
        check("drain.out_valid", 32'(out_valid), 32'd0);
        check("drain.out_data",  32'(out_data),  32'hA);
        check("drain.out_sel",   32'(out_sel),   32'd0);

        // Single requester on channel 2 (ptr=1 here)
        cyc(4'b0100, 1'b1, 4'b0100, 1'b0, "single0");
        cyc(4'b0100, 1'b1, 4'b0100, 1'b1, "single1");
        cyc(4'b0100, 1'b1, 4'b0100, 1'b1, "single2");

        // Move ptr to 2 by granting channel 1, then skip idle channels
        cyc(4'b0010, 1'b1, 4'b0010, 1'b1, "setptr");
        cyc(4'b1010, 1'b1, 4'b1000, 1'b1, "skip3");
        cyc(4'b1010, 1'b1, 4'b0010, 1'b1, "skip1");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "skipdrain");

        // Backpressure: hold beat 5 for three cycles
        dv[2] = 4'h5;
        cyc(4'b0100, 1'b1, 4'b0100, 1'b0, "bp_load");
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b0, 4'b0000, 1'b1, $sformatf("bp_hold%0d", i));
            check($sformatf("bp_hold%0d.out_data", i), 32'(out_data), 32'h5);
        end
        cyc(4'b1111, 1'b1, 4'b1000, 1'b1, "bp_release");
        check("bp_next.out_data", 32'(out_data), 32'hD);
        check("bp_next.out_sel",  32'(out_sel),  32'd3);

        // Async reset between edges with beat D (sel 3) held
        req_valid = 4'b0000;
        out_ready = 1'b0;
        void'(sb.pop_back());  // held beat is discarded by reset
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.out_data",  32'(out_data),  32'd0);
        check("arst.out_sel",   32'(out_sel),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(4'b1111, 1'b1, 4'b0001, 1'b0, "post_rst");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b1, "post_drain");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "idle");

        check("sb.empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
